// File: rtl/ddc_pkg.sv
// DDC sample streamer shared definitions.
// Output FSM states, default sample width and a clog2 helper.
package ddc_pkg;

  localparam int DDCOUT_WIDTH = 25;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } out_state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ddc_sync_fifo.sv
// Single-clock dual-pointer RAM FIFO with registered read.
// rd_data_o always holds the current head one cycle after any change.
module ddc_sync_fifo
  import ddc_pkg::*;
#(
  parameter int DW    = 50,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     clr_i,
  input  logic                     wr_en_i,
  input  logic [DW-1:0]            wr_data_i,
  input  logic                     rd_en_i,
  output logic [DW-1:0]            rd_data_o,
  output logic [clog2(DEPTH):0]    count_o,
  output logic                     empty_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] rd_data_q;

  // Next pointer and occupancy values.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(wr_en_i);
    rd_ptr_d = rd_ptr_q + AW'(rd_en_i);
    count_d  = count_q + CW'(wr_en_i) - CW'(rd_en_i);
  end

  // RAM write port; storage itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, count and registered head read with write-through.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else if (clr_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      if (wr_en_i && (wr_ptr_q == rd_ptr_d)) begin
        rd_data_q <= wr_data_i;
      end else begin
        rd_data_q <= mem_q[rd_ptr_d];
      end
    end
  end

  assign rd_data_o = rd_data_q;
  assign count_o   = count_q;
  assign empty_o   = (count_q == '0);

endmodule

// File: rtl/ddc_sample_streamer.sv
// Buffers DDC I/Q pairs and streams them out as framed valid/ready beats.
// Output register plus FIFO; level counts both, drops are counted.
module ddc_sample_streamer
  import ddc_pkg::*;
#(
  parameter int DATA_WIDTH = DDCOUT_WIDTH,
  parameter int FIFO_DEPTH = 16,
  parameter int FRAME_LEN  = 64
) (
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [DATA_WIDTH-1:0]        idata_i,
  input  logic [DATA_WIDTH-1:0]        qdata_i,
  input  logic                         val_i,
  output logic [2*DATA_WIDTH-1:0]      tdata_o,
  output logic                         tvalid_o,
  input  logic                         tready_i,
  output logic                         tlast_o,
  output logic [clog2(FIFO_DEPTH):0]   level_o,
  output logic                         overflow_o,
  output logic [15:0]                  drop_cnt_o
);

  localparam int LW = clog2(FIFO_DEPTH) + 1;
  localparam int FW = clog2(FRAME_LEN);
  localparam int PW = 2 * DATA_WIDTH;

  out_state_e    state_q, state_d;
  logic [PW-1:0] out_q;
  logic [FW-1:0] frame_q;
  logic          ovf_q;
  logic [15:0]   drop_q;

  logic [PW-1:0] fifo_rdata;
  logic [LW-1:0] fifo_cnt;
  logic          fifo_empty;
  logic          push, pop, load_in;

  logic [LW-1:0] level;
  logic          present, full, smp, wr, drop, xfer, last;

  assign present = (state_q == ST_PRESENT);
  assign level   = fifo_cnt + LW'(present);
  assign full    = (level == LW'(FIFO_DEPTH));
  assign smp     = val_i & en_i & ~clr_i;
  assign wr      = smp & ~full;
  assign drop    = smp & full;
  assign xfer    = present & tready_i;
  assign last    = (frame_q == FW'(FRAME_LEN - 1));

  ddc_sync_fifo #(
    .DW    (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clr_i     (clr_i),
    .wr_en_i   (push),
    .wr_data_i ({qdata_i, idata_i}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rdata),
    .count_o   (fifo_cnt),
    .empty_o   (fifo_empty)
  );

  // Output FSM state register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and routing of new samples: bypass to output or queue.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    load_in = 1'b0;
    if (clr_i) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (wr) begin
            load_in = 1'b1;
            state_d = ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (xfer) begin
            if (!fifo_empty) begin
              pop  = 1'b1;
              push = wr;
            end else if (wr) begin
              load_in = 1'b1;
            end else begin
              state_d = ST_EMPTY;
            end
          end else begin
            push = wr;
          end
        end
      endcase
    end
  end

  // Output data register, loaded from input bypass or FIFO head.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_q <= '0;
    end else if (clr_i) begin
      out_q <= '0;
    end else if (load_in) begin
      out_q <= {qdata_i, idata_i};
    end else if (pop) begin
      out_q <= fifo_rdata;
    end
  end

  // Frame position of the presented pair; wraps after the last beat.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      frame_q <= '0;
    end else if (clr_i) begin
      frame_q <= '0;
    end else if (xfer) begin
      frame_q <= last ? '0 : frame_q + 1'b1;
    end
  end

  // Sticky overflow and saturating drop counter.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (clr_i) begin
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovf_q <= 1'b1;
      if (drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign tdata_o    = out_q;
  assign tvalid_o   = present;
  assign tlast_o    = present & last;
  assign level_o    = level;
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_ddc_sample_streamer.sv
// Directed bench for ddc_sample_streamer.
// Queue model checked every cycle plus literal expectations.
module tb_ddc_sample_streamer;

  localparam int DW    = 25;
  localparam int DEPTH = 16;
  localparam int FLEN  = 64;
  localparam int PW    = 2 * DW;
  localparam int LW    = 5;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic          en     = 1'b0;
  logic          clr    = 1'b0;
  logic          val    = 1'b0;
  logic          tready = 1'b0;
  logic [DW-1:0] idata  = '0;
  logic [DW-1:0] qdata  = '0;
  logic [PW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [LW-1:0] level;
  logic          ovf;
  logic [15:0]   dcnt;

  ddc_sample_streamer dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .en_i       (en),
    .clr_i      (clr),
    .idata_i    (idata),
    .qdata_i    (qdata),
    .val_i      (val),
    .tdata_o    (tdata),
    .tvalid_o   (tvalid),
    .tready_i   (tready),
    .tlast_o    (tlast),
    .level_o    (level),
    .overflow_o (ovf),
    .drop_cnt_o (dcnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of pairs visible at the output side.
  logic [PW-1:0] mq[$];
  int            mframe = 0;
  bit            movf   = 0;
  int            mdrop  = 0;
  bit            mfull;

  always @(posedge clk) begin
    if (rst_n) begin
      if (clr) begin
        mq.delete();
        mframe = 0;
        movf   = 0;
        mdrop  = 0;
      end else begin
        mfull = (mq.size() == DEPTH);
        if (mq.size() > 0 && tready) begin
          void'(mq.pop_front());
          mframe = (mframe + 1) % FLEN;
        end
        if (en && val) begin
          if (mfull) begin
            movf = 1;
            if (mdrop < 65535) mdrop++;
          end else begin
            mq.push_back({qdata, idata});
          end
        end
      end
    end
  end

  always @(negedge rst_n) begin
    mq.delete();
    mframe = 0;
    movf   = 0;
    mdrop  = 0;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("tvalid", 64'(tvalid), 64'(mq.size() > 0));
      chk("level", 64'(level), 64'(mq.size()));
      chk("overflow", 64'(ovf), 64'(movf));
      chk("drop_cnt", 64'(dcnt), 64'(mdrop));
      if (mq.size() > 0) begin
        chk("tdata", 64'(tdata), 64'(mq[0]));
        chk("tlast", 64'(tlast), 64'(mframe == FLEN - 1));
      end
    end
  end

  // Transfer log used by the literal frame/order expectations.
  logic [PW-1:0] xlog[$];
  int            xcount = 0;
  int            last_at[$];

  always @(negedge clk) begin
    if (rst_n && tvalid && tready && !clr) begin
      xcount++;
      xlog.push_back(tdata);
      if (tlast) last_at.push_back(xcount);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    xcount = 0;
    xlog.delete();
    last_at.delete();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    clear_log();
  endtask

  task automatic send(input int i, input int q);
    idata = DW'(i);
    qdata = DW'(q);
    val   = 1'b1;
    tick();
    val   = 1'b0;
  endtask

  task automatic chk_zero_outputs(string tag);
    chk({tag, "_tvalid"}, 64'(tvalid), 64'd0);
    chk({tag, "_tlast"}, 64'(tlast), 64'd0);
    chk({tag, "_tdata"}, 64'(tdata), 64'd0);
    chk({tag, "_level"}, 64'(level), 64'd0);
    chk({tag, "_ovf"}, 64'(ovf), 64'd0);
    chk({tag, "_drop"}, 64'(dcnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    // Single sample latency and packing.
    tready = 1'b1;
    send(32'h0000123, 32'h1FFFFFF);
    chk("single_tvalid", 64'(tvalid), 64'd1);
    chk("single_tdata", 64'(tdata), 64'h3FFFFFE000123);
    chk("single_level", 64'(level), 64'd1);
    tick();
    chk("single_level_after", 64'(level), 64'd0);
    chk("single_tvalid_after", 64'(tvalid), 64'd0);

    // Sparse strobes over two frames.
    pulse_clr();
    tready = 1'b1;
    for (int k = 0; k < 130; k++) begin
      send(k + 1, -(k + 1));
      repeat (49) tick();
    end
    chk("strobe_xfers", 64'(xcount), 64'd130);
    chk("strobe_nlast", 64'(last_at.size()), 64'd2);
    chk("strobe_last0", 64'(last_at.size() > 0 ? last_at[0] : 0), 64'd64);
    chk("strobe_last1", 64'(last_at.size() > 1 ? last_at[1] : 0), 64'd128);
    chk("strobe_first", 64'(xlog.size() > 0 ? xlog[0] : '0), 64'h3FFFFFE000001);

    // Fill past capacity with the sink stalled.
    pulse_clr();
    tready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      idata = DW'(100 + k);
      qdata = DW'(200 + k);
      val   = 1'b1;
      tick();
    end
    val = 1'b0;
    chk("fill_level", 64'(level), 64'd16);
    chk("fill_ovf", 64'(ovf), 64'd1);
    chk("fill_drop", 64'(dcnt), 64'd4);
    tready = 1'b1;
    repeat (20) tick();
    chk("fill_xfers", 64'(xcount), 64'd16);
    chk("fill_first", 64'(xlog.size() > 0 ? xlog[0] : '0), {39'd200, 25'd100});
    chk("fill_16th", 64'(xlog.size() > 15 ? xlog[15] : '0), {39'd215, 25'd115});
    chk("fill_drained", 64'(level), 64'd0);

    // Full with a coincident transfer and write.
    pulse_clr();
    tready = 1'b0;
    for (int k = 0; k < 16; k++) send(300 + k, 400 + k);
    chk("full_level", 64'(level), 64'd16);
    chk("full_drop0", 64'(dcnt), 64'd0);
    tready = 1'b1;
    send(999, 999);
    tready = 1'b0;
    chk("full_xw_level", 64'(level), 64'd15);
    chk("full_xw_drop", 64'(dcnt), 64'd1);
    chk("full_xw_ovf", 64'(ovf), 64'd1);
    tready = 1'b1;
    repeat (20) tick();

    // Clear mid-frame with samples buffered and a strobe pending.
    pulse_clr();
    tready = 1'b1;
    for (int k = 0; k < 10; k++) send(600 + k, 700 + k);
    repeat (2) tick();
    tready = 1'b0;
    for (int k = 0; k < 5; k++) send(800 + k, 900 + k);
    chk("clr_pre_level", 64'(level), 64'd5);
    clr   = 1'b1;
    val   = 1'b1;
    idata = DW'(1234);
    tick();
    clr = 1'b0;
    val = 1'b0;
    chk("clr_tvalid", 64'(tvalid), 64'd0);
    chk("clr_level", 64'(level), 64'd0);
    chk("clr_ovf", 64'(ovf), 64'd0);
    clear_log();
    tready = 1'b1;
    for (int k = 0; k < 70; k++) send(k, 1000 + k);
    repeat (3) tick();
    chk("clr_last0", 64'(last_at.size() > 0 ? last_at[0] : 0), 64'd64);

    // Asynchronous reset mid-transfer with a random sink.
    pulse_clr();
    for (int k = 0; k < 30; k++) begin
      tready = 1'($urandom_range(0, 1));
      send(500 + k, 1500 + k);
    end
    tready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("arst");
    tick();
    tick();
    rst_n = 1'b1;
    clear_log();
    for (int k = 0; k < 70; k++) send(2000 + k, 3000 + k);
    repeat (3) tick();
    chk("arst_xfers", 64'(xcount), 64'd70);
    chk("arst_last0", 64'(last_at.size() > 0 ? last_at[0] : 0), 64'd64);
    chk("arst_first", 64'(xlog.size() > 0 ? xlog[0] : '0), {39'd3000, 25'd2000});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
